// File: rtl/sdram_ctrl.sv
// Single-port SDR SDRAM controller: power-up init, periodic auto-refresh and
// single-word READ/WRITE accesses with auto-precharge for one requester.
module sdram_ctrl #(
    parameter int INIT_CYCLES    = 20000,
    parameter int REFRESH_CYCLES = 780,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 7,
    parameter int T_MRD          = 2,
    parameter int T_RCD          = 2,
    parameter int T_WR           = 2,
    parameter int CAS_LATENCY    = 2
) (
    input  logic        sysClk,
    input  logic        rstN,
    output logic        ready,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        sdCke,
    output logic        sdCsN,
    output logic        sdRasN,
    output logic        sdCasN,
    output logic        sdWeN,
    output logic [1:0]  sdBa,
    output logic [12:0] sdAddr,
    output logic [1:0]  sdDqm,
    output logic [15:0] sdDqOut,
    output logic        sdDqOe,
    input  logic [15:0] sdDqIn
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;

    localparam int CNT_W = $clog2(INIT_CYCLES + 64);
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [2:0]  CL_BITS   = 3'(CAS_LATENCY);
    localparam logic [12:0] MODE_WORD = {3'b000, 1'b0, 2'b00, CL_BITS, 1'b0, 3'b000};

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_LMR,
        S_IDLE, S_AREF, S_ACT, S_RD, S_RDCAP, S_WR, S_WAIT
    } state_t;

    state_t             state_reg;
    state_t             next_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [3:0]         cmd_reg;
    logic [REF_W-1:0]   ref_cnt_reg;
    logic               ref_en_reg;
    logic               ref_pending_reg;
    logic               we_reg;
    logic [8:0]         col_reg;
    logic [15:0]        wdata_reg;

    assign {sdCsN, sdRasN, sdCasN, sdWeN} = cmd_reg;

    // Every command state lasts one cycle; S_WAIT then burns the remaining
    // cycles so that the next state's command lands exactly T clocks later.
    always_ff @(posedge sysClk) begin
        if (!rstN) begin
            state_reg       <= S_INIT_WAIT;
            next_reg        <= S_INIT_WAIT;
            cnt_reg         <= '0;
            cmd_reg         <= CMD_NOP;
            ref_cnt_reg     <= '0;
            ref_en_reg      <= 1'b0;
            ref_pending_reg <= 1'b0;
            we_reg          <= 1'b0;
            col_reg         <= '0;
            wdata_reg       <= '0;
            sdCke           <= 1'b0;
            sdBa            <= '0;
            sdAddr          <= '0;
            sdDqm           <= 2'b11;
            sdDqOut         <= '0;
            sdDqOe          <= 1'b0;
            ready           <= 1'b0;
            ack             <= 1'b0;
            rvalid          <= 1'b0;
            rdata           <= '0;
        end else begin
            cmd_reg <= CMD_NOP;
            sdDqm   <= 2'b11;
            sdDqOe  <= 1'b0;
            sdDqOut <= '0;
            ack     <= 1'b0;
            rvalid  <= 1'b0;
            case (state_reg)
                S_INIT_WAIT: begin
                    sdCke <= 1'b1;
                    if (cnt_reg == CNT_W'(INIT_CYCLES)) begin
                        state_reg <= S_INIT_PRE;
                        cmd_reg   <= CMD_PRE;
                        sdBa      <= '0;
                        sdAddr    <= 13'h0400;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_INIT_PRE: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_INIT_REF1;
                    cnt_reg   <= CNT_W'(T_RP - 2);
                end
                S_INIT_REF1: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_INIT_REF2;
                    cnt_reg   <= CNT_W'(T_RFC - 2);
                end
                S_INIT_REF2: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_INIT_LMR;
                    cnt_reg   <= CNT_W'(T_RFC - 2);
                end
                S_INIT_LMR: begin
                    state_reg  <= S_WAIT;
                    next_reg   <= S_IDLE;
                    cnt_reg    <= CNT_W'(T_MRD - 2);
                    ref_en_reg <= 1'b1;
                end
                S_IDLE: begin
                    if (ref_pending_reg) begin
                        state_reg       <= S_AREF;
                        cmd_reg         <= CMD_REF;
                        ref_pending_reg <= 1'b0;
                    end else if (req) begin
                        state_reg <= S_ACT;
                        cmd_reg   <= CMD_ACT;
                        ack       <= 1'b1;
                        sdBa      <= addr[10:9];
                        sdAddr    <= addr[23:11];
                        we_reg    <= we;
                        col_reg   <= addr[8:0];
                        wdata_reg <= wdata;
                    end
                end
                S_AREF: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_IDLE;
                    cnt_reg   <= CNT_W'(T_RFC - 2);
                end
                S_ACT: begin
                    state_reg <= S_WAIT;
                    next_reg  <= we_reg ? S_WR : S_RD;
                    cnt_reg   <= CNT_W'(T_RCD - 2);
                end
                S_RD: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_RDCAP;
                    cnt_reg   <= CNT_W'(CAS_LATENCY - 1);
                end
                S_RDCAP: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_IDLE;
                    cnt_reg   <= CNT_W'(T_RP - 2);
                end
                S_WR: begin
                    state_reg <= S_WAIT;
                    next_reg  <= S_IDLE;
                    cnt_reg   <= CNT_W'(T_WR + T_RP - 2);
                end
                S_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= next_reg;
                        case (next_reg)
                            S_INIT_REF1, S_INIT_REF2: cmd_reg <= CMD_REF;
                            S_INIT_LMR: begin
                                cmd_reg <= CMD_LMR;
                                sdBa    <= '0;
                                sdAddr  <= MODE_WORD;
                            end
                            S_IDLE: ready <= 1'b1;
                            S_RD: begin
                                cmd_reg <= CMD_RD;
                                sdAddr  <= {4'b0010, col_reg};
                                sdDqm   <= 2'b00;
                            end
                            S_WR: begin
                                cmd_reg <= CMD_WR;
                                sdAddr  <= {4'b0010, col_reg};
                                sdDqm   <= 2'b00;
                                sdDqOe  <= 1'b1;
                                sdDqOut <= wdata_reg;
                            end
                            S_RDCAP: begin
                                rvalid <= 1'b1;
                                rdata  <= sdDqIn;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= S_INIT_WAIT;
            endcase

            // A new expiry overrides a same-cycle clear; a second one is not queued.
            if (ref_en_reg) begin
                if (ref_cnt_reg == REF_W'(REFRESH_CYCLES - 1)) begin
                    ref_cnt_reg     <= '0;
                    ref_pending_reg <= 1'b1;
                end else begin
                    ref_cnt_reg <= ref_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Bench for sdram_ctrl: pin-level SDRAM model plus a read-data scoreboard.
module tb_sdram_ctrl;

    localparam int INIT_N = 10;
    localparam int REF_N  = 50;
    localparam int T_RP   = 2;
    localparam int T_RFC  = 7;
    localparam int T_MRD  = 2;
    localparam int T_RCD  = 2;
    localparam int CL     = 2;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;

    logic        sysClk = 1'b0;
    logic        rstN;
    logic        ready;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        rvalid;
    logic        sdCke, sdCsN, sdRasN, sdCasN, sdWeN;
    logic [1:0]  sdBa;
    logic [12:0] sdAddr;
    logic [1:0]  sdDqm;
    logic [15:0] sdDqOut;
    logic        sdDqOe;
    logic [15:0] sdDqIn = 16'hDEAD;
    logic [3:0]  cmd;

    assign cmd = {sdCsN, sdRasN, sdCasN, sdWeN};

    sdram_ctrl #(
        .INIT_CYCLES(INIT_N), .REFRESH_CYCLES(REF_N), .T_RP(T_RP), .T_RFC(T_RFC),
        .T_MRD(T_MRD), .T_RCD(T_RCD), .T_WR(2), .CAS_LATENCY(CL)
    ) dut (
        .sysClk(sysClk), .rstN(rstN), .ready(ready), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .rvalid(rvalid),
        .sdCke(sdCke), .sdCsN(sdCsN), .sdRasN(sdRasN), .sdCasN(sdCasN), .sdWeN(sdWeN),
        .sdBa(sdBa), .sdAddr(sdAddr), .sdDqm(sdDqm), .sdDqOut(sdDqOut),
        .sdDqOe(sdDqOe), .sdDqIn(sdDqIn)
    );

    always #5 sysClk = ~sysClk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ref_cyc = -1;
    int rvalid_cnt = 0;
    int rd_due = -1;
    logic [23:0] rd_key;
    logic [12:0] open_row [4];
    logic [15:0] mem [logic [23:0]];
    logic [15:0] shadow [logic [23:0]];
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM model and read scoreboard, sampled 2 ns after each rising edge.
    always begin
        @(posedge sysClk);
        #2;
        cyc++;
        if (cmd == C_REF) last_ref_cyc = cyc;
        if (cmd == C_ACT) open_row[sdBa] = sdAddr;
        if (cmd == C_WR) mem[{open_row[sdBa], sdBa, sdAddr[8:0]}] = sdDqOut;
        if (cmd == C_RD) begin
            rd_due = cyc + CL;
            rd_key = {open_row[sdBa], sdBa, sdAddr[8:0]};
        end
        sdDqIn = (cyc == rd_due && mem.exists(rd_key)) ? mem[rd_key] : 16'hDEAD;
        if (rvalid) begin
            rvalid_cnt++;
            if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
            else check("rdata", {16'h0, rdata}, {16'h0, exp_q.pop_front()});
        end
    end

    task automatic wait_cmd(output int d);
        d = 0;
        do begin
            @(negedge sysClk);
            d++;
        end while (cmd == C_NOP && d < 300);
    endtask

    task automatic check_init();
        int d;
        for (int i = 0; i < INIT_N; i++) begin
            @(negedge sysClk);
            check("init_nop", {sdCke, cmd, ready}, {1'b1, C_NOP, 1'b0});
        end
        @(negedge sysClk);
        check("init_pre", {cmd, sdAddr[10]}, {C_PRE, 1'b1});
        wait_cmd(d);
        check("init_ref1_gap", d, T_RP);
        check("init_ref1", cmd, C_REF);
        wait_cmd(d);
        check("init_ref2_gap", d, T_RFC);
        check("init_ref2", cmd, C_REF);
        wait_cmd(d);
        check("init_lmr_gap", d, T_RFC);
        check("init_lmr", {cmd, sdBa, sdAddr}, {C_LMR, 2'b00, 13'h020});
        d = 0;
        do begin
            @(negedge sysClk);
            d++;
        end while (!ready && d < 50);
        check("ready_delay", d, T_MRD);
    endtask

    // Called at a falling edge; returns at the falling edge of the last checked cycle.
    task automatic access(input bit w, input logic [23:0] a, input logic [15:0] dat,
                          input bit abort, output int wt);
        int d;
        we = w; addr = a; wdata = dat; req = 1'b1;
        if (w) shadow[a] = dat;
        else exp_q.push_back(shadow.exists(a) ? shadow[a] : 16'h0);
        wt = 0;
        do begin
            @(negedge sysClk);
            wt++;
        end while (!ack && wt < 300);
        req = 1'b0;
        $display("access %s addr=%h data=%h ack_wait=%0d", w ? "WR" : "RD", a, dat, wt);
        check("ack", ack, 1'b1);
        check("act", {cmd, sdBa, sdAddr}, {C_ACT, a[10:9], a[23:11]});
        wait_cmd(d);
        check("t_rcd", d, T_RCD);
        check("rw_cmd", {cmd, sdDqm, sdAddr}, {w ? C_WR : C_RD, 2'b00, 4'b0010, a[8:0]});
        if (w) begin
            check("wr_data", {sdDqOe, sdDqOut}, {1'b1, dat});
            @(negedge sysClk);
            check("wr_oe_off", {sdDqOe, sdDqm}, 3'b011);
        end else if (!abort) begin
            d = 0;
            do begin
                @(negedge sysClk);
                d++;
            end while (!rvalid && d < 20);
            check("cas_latency", d, CL + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wt, d, r, n0;
        logic [23:0] ra [3];
        logic [15:0] rd [3];
        rstN = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge sysClk);
        check("rst_pins", {sdCke, cmd, sdDqm, sdDqOe}, {1'b0, C_NOP, 2'b11, 1'b0});
        check("rst_addr", {sdBa, sdAddr, sdDqOut}, 31'h0);
        check("rst_user", {ready, ack, rvalid, rdata}, 19'h0);
        rstN = 1'b1;
        check_init();

        access(1'b1, 24'hABCDE5, 16'h5A5A, 1'b0, wt);
        check("first_ack_wait", wt, 1);
        access(1'b0, 24'hABCDE5, 16'h0, 1'b0, wt);
        for (int i = 0; i < 3; i++) begin
            ra[i] = 24'($urandom);
            rd[i] = 16'($urandom);
            access(1'b1, ra[i], rd[i], 1'b0, wt);
        end
        for (int i = 0; i < 3; i++) access(1'b0, ra[i], 16'h0, 1'b0, wt);

        // Idle refresh cadence.
        wait_cmd(d);
        check("refresh_idle", cmd, C_REF);
        wait_cmd(d);
        check("refresh_period", d, REF_N);
        check("refresh_again", cmd, C_REF);

        // Request arrives in the cycle refresh becomes pending.
        r = cyc;
        repeat (REF_N - 1) @(negedge sysClk);
        access(1'b1, 24'h123456, 16'hC3C3, 1'b0, wt);
        check("refresh_first", last_ref_cyc, r + REF_N);
        check("ack_after_refresh", wt, T_RFC + 2);
        access(1'b0, 24'h123456, 16'h0, 1'b0, wt);

        // Reset one cycle after a READ: read is dropped, init replays.
        access(1'b0, 24'hABCDE5, 16'h0, 1'b1, wt);
        n0 = rvalid_cnt;
        @(negedge sysClk);
        rstN = 1'b0;
        @(negedge sysClk);
        check("midrst_pins", {sdCke, cmd, ready, sdDqm}, {1'b0, C_NOP, 1'b0, 2'b11});
        rstN = 1'b1;
        check_init();
        check("no_rvalid_after_reset", rvalid_cnt, n0);
        exp_q.delete();
        access(1'b0, 24'hABCDE5, 16'h0, 1'b0, wt);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
